// File: rtl/encoder_activation_seq.sv
// encoder_activation_seq: captures an encoder result vector and applies ReLU or hard sigmoid
// one element per cycle, then presents the activated vector downstream with valid/ready.
module encoder_activation_seq #(
    parameter int M_OUTPUT  = 4,
    parameter int BITSIZE   = 32,
    parameter int FRAC_BITS = 16,
    parameter int ACT_TYPE  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [M_OUTPUT*BITSIZE-1:0]  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [M_OUTPUT*BITSIZE-1:0]  out_data,
    output logic                         busy
);
    localparam int IW = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
    localparam logic [IW-1:0] LAST = IW'(M_OUTPUT - 1);
    localparam logic signed [BITSIZE:0] ONE  = (BITSIZE+1)'(1) << FRAC_BITS;
    localparam logic signed [BITSIZE:0] HALF = ONE >>> 1;

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t                      state, state_next;
    logic [IW-1:0]               idx;
    logic [M_OUTPUT*BITSIZE-1:0] cap;
    logic signed [BITSIZE-1:0]   cur, act;
    logic signed [BITSIZE:0]     t;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = state;
        state_next = (state == IDLE && in_valid)    ? PROC :
                     (state == PROC && idx == LAST) ? DONE :
                     (state == DONE && out_ready)   ? IDLE : state;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // hard sigmoid works one bit wider so the +0.5 offset cannot wrap before the clamp
    always_comb begin
        cur = cap[idx*BITSIZE +: BITSIZE];
        t   = {{3{cur[BITSIZE-1]}}, cur[BITSIZE-1:2]} + HALF;
        act = (ACT_TYPE == 0) ? (cur[BITSIZE-1] ? '0 : cur) :
              (ACT_TYPE == 1) ? (t[BITSIZE] ? '0 : (t > ONE) ? ONE[BITSIZE-1:0] : t[BITSIZE-1:0]) :
              cur;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx      <= '0;
            cap      <= '0;
            out_data <= '0;
        end else if (state == IDLE && in_valid) begin
            cap <= in_data;
            idx <= '0;
        end else if (state == PROC) begin
            out_data[idx*BITSIZE +: BITSIZE] <= act;
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
endmodule

// File: tb/tb_encoder_activation_seq.sv
// tb_encoder_activation_seq: directed vectors against hard-sigmoid, ReLU and identity builds
// sharing one stimulus, plus backpressure, mid-op reset and back-to-back sequences.
module tb_encoder_activation_seq;
    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [127:0] in_data = '0;
    logic in_ready, out_valid, busy, ir0, ov0, b0, ir2, ov2, b2;
    logic [127:0] od1, od0, od2;

    always #5 clk = ~clk;

    encoder_activation_seq #(.ACT_TYPE(1)) dut_sig (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(od1), .busy(busy));
    encoder_activation_seq #(.ACT_TYPE(0)) dut_relu (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .busy(b0));
    encoder_activation_seq #(.ACT_TYPE(2)) dut_id (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(b2));

    typedef struct packed {
        logic [127:0] din;
        logic [127:0] sig;
        logic [127:0] relu;
    } vec_t;

    vec_t tbl [4];
    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int k);
        chk({nm, " sigmoid"}, od1, tbl[k].sig);
        chk({nm, " relu"}, od0, tbl[k].relu);
        chk({nm, " identity"}, od2, tbl[k].din);
    endtask

    task automatic accept(input logic [127:0] d);
        @(negedge clk);
        chk("in_ready before accept", in_ready, 1);
        in_data  = d;
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        chk("busy after accept", busy, 1);
        chk("in_ready after accept", in_ready, 0);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, n, 4);
    endtask

    task automatic release_vec(input int k);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("out_valid after handshake", out_valid, 0);
        chk("in_ready after handshake", in_ready, 1);
        chk("out_data held after handshake", od1, tbl[k].sig);
    endtask

    task automatic run_vec(input int k);
        accept(tbl[k].din);
        wait_done($sformatf("vec%0d", k));
        chk_out($sformatf("vec%0d", k), k);
        release_vec(k);
    endtask

    initial begin
        int acc, outs;
        int ac [3];
        tbl[0] = '{din:  {32'hFFFE0000, 32'h00010000, 32'h00020000, 32'h00000000},
                   sig:  {32'h00000000, 32'h0000C000, 32'h00010000, 32'h00008000},
                   relu: {32'h00000000, 32'h00010000, 32'h00020000, 32'h00000000}};
        tbl[1] = '{din:  {32'hFFFD0000, 32'h00040000, 32'h80000000, 32'h7FFFFFFF},
                   sig:  {32'h00000000, 32'h00010000, 32'h00000000, 32'h00010000},
                   relu: {32'h00000000, 32'h00040000, 32'h00000000, 32'h7FFFFFFF}};
        tbl[2] = '{din:  {32'h7FFFFFFF, 32'h80000000, 32'h00018000, 32'hFFFF8000},
                   sig:  {32'h00010000, 32'h00000000, 32'h0000E000, 32'h00006000},
                   relu: {32'h7FFFFFFF, 32'h00000000, 32'h00018000, 32'h00000000}};
        tbl[3] = '{din:  {32'hFFFFFFFF, 32'h00020004, 32'hFFFDFFFF, 32'hFFFE0001},
                   sig:  {32'h00007FFF, 32'h00010000, 32'h00000000, 32'h00000000},
                   relu: {32'h00000000, 32'h00020004, 32'h00000000, 32'h00000000}};

        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", od1, 0);
        rst_n = 1;
        @(negedge clk);
        chk("in_ready after release", in_ready, 1);

        for (int k = 0; k < 4; k++) run_vec(k);

        // backpressure: vector 2 held in DONE while a new vector waits on the input
        accept(tbl[2].din);
        wait_done("bp");
        in_data  = tbl[0].din;
        in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp out_valid", out_valid, 1);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_data", od1, tbl[2].sig);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("bp idle out_valid", out_valid, 0);
        chk("bp idle in_ready", in_ready, 1);
        chk("bp idle out_data", od1, tbl[2].sig);
        @(negedge clk);
        in_valid = 0;
        chk("bp waiting vector accepted", busy, 1);
        wait_done("bp next");
        chk_out("bp next", 0);
        release_vec(0);

        // asynchronous reset two cycles after accept
        accept(tbl[1].din);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rst mid out_valid", out_valid, 0);
        chk("rst mid out_data", od1, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        run_vec(3);

        // back-to-back with in_valid and out_ready high
        acc = 0;
        outs = 0;
        out_ready = 1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (outs < 3) chk_out($sformatf("b2b out%0d", outs), outs);
                outs++;
            end
            if (in_ready) begin
                if (acc < 3) begin
                    in_data  = tbl[acc].din;
                    in_valid = 1;
                    ac[acc]  = c;
                    acc++;
                end else in_valid = 0;
            end
        end
        out_ready = 0;
        in_valid = 0;
        chk("b2b accepts", acc, 3);
        chk("b2b outputs", outs, 3);
        chk("b2b spacing 0-1", ac[1] - ac[0], 6);
        chk("b2b spacing 1-2", ac[2] - ac[1], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
